// File: rtl/wb_ctrl.sv
// wb_ctrl: write-back sequencer for the 8-bit datapath.
// ALU results are written to the register file one cycle after acceptance.
// A load first issues a one-cycle memory read strobe.
// It then waits MEM_LAT cycles and writes the returned memory value.
// Execute is back-pressured until the load write cycle is reached.
module wb_ctrl #(
    parameter int ADDR_W  = 3,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic              wb_is_load,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic              flush,
    output logic              mem_rd_en,
    output logic              mem_sel,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_waddr,
    output logic              stall,
    output logic [7:0]        load_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    // Number of WAIT cycles between the read strobe and the write.
    // A value of zero means RD goes straight to WB.
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [3:0]        lat_cnt;
    logic [3:0]        lat_cnt_nxt;
    logic [ADDR_W-1:0] dest_q;
    logic              accept;
    logic              enter_wb;

    // Handshake: only idle or the final load-write cycle can take a new request
    always_comb begin
        wb_ready = ((state == S_IDLE) || (state == S_WB)) && !flush;
        stall    = !wb_ready;
        accept   = wb_valid && wb_ready;
    end

    // Next-state and latency-countdown logic; flush abandons an outstanding read
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        case (state)
            S_IDLE, S_WB: begin
                state_nxt = (accept && wb_is_load) ? S_RD : S_IDLE;
            end
            S_RD: begin
                if (flush) begin
                    state_nxt   = S_IDLE;
                    lat_cnt_nxt = 4'd0;
                end else if (LAT_M1 == 4'd0) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt   = S_WAIT;
                    lat_cnt_nxt = LAT_M1;
                end
            end
            default: begin
                lat_cnt_nxt = lat_cnt - 4'd1;
                if (flush) begin
                    state_nxt   = S_IDLE;
                    lat_cnt_nxt = 4'd0;
                end else if (lat_cnt_nxt == 4'd0) begin
                    state_nxt = S_WB;
                end
            end
        endcase
        enter_wb = (state_nxt == S_WB);
    end

    // State, countdown and captured load destination
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            lat_cnt <= 4'd0;
            dest_q  <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
            if (accept) begin
                dest_q <= wb_dest;
            end
        end
    end

    // Registered datapath controls for the cycle following each decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_en <= 1'b0;
            mem_sel   <= 1'b0;
            reg_we    <= 1'b0;
            reg_waddr <= '0;
        end else begin
            mem_rd_en <= accept && wb_is_load;
            mem_sel   <= (state_nxt != S_IDLE);
            reg_we    <= (accept && !wb_is_load) || enter_wb;
            if (accept && !wb_is_load) begin
                reg_waddr <= wb_dest;
            end else if (enter_wb) begin
                reg_waddr <= dest_q;
            end
        end
    end

    // Saturating count of load write-backs, bumped as the write is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt <= 8'd0;
        end else if (enter_wb && (load_cnt != 8'hFF)) begin
            load_cnt <= load_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: three wb_ctrl instances (MEM_LAT = 2, 3, 1) driven by shared inputs.
// Each instance is compared every cycle against a timeline model.
// The model tracks each load by its cycle index since acceptance.
module tb_wb_ctrl;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wb_valid = 1'b0;
    logic       wb_is_load = 1'b0;
    logic [2:0] wb_dest = 3'd0;
    logic       flush = 1'b0;

    logic [NI-1:0] ready_a;
    logic [NI-1:0] stall_a;
    logic [NI-1:0] rd_a;
    logic [NI-1:0] sel_a;
    logic [NI-1:0] we_a;
    logic [2:0]    waddr_a [NI];
    logic [7:0]    cnt_a   [NI];

    int checks = 0;
    int errors = 0;

    int lat [NI] = '{2, 3, 1};
    int mk      [NI];
    int mdest   [NI];
    int e_waddr [NI];
    int e_cnt   [NI];
    bit e_rd    [NI];
    bit e_sel   [NI];
    bit e_we    [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        wb_ctrl #(
            .ADDR_W (3),
            .MEM_LAT((g == 0) ? 2 : ((g == 1) ? 3 : 1))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .wb_valid  (wb_valid),
            .wb_ready  (ready_a[g]),
            .wb_is_load(wb_is_load),
            .wb_dest   (wb_dest),
            .flush     (flush),
            .mem_rd_en (rd_a[g]),
            .mem_sel   (sel_a[g]),
            .reg_we    (we_a[g]),
            .reg_waddr (waddr_a[g]),
            .stall     (stall_a[g]),
            .load_cnt  (cnt_a[g])
        );
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit modelReady(input int i, input bit fl);
        return ((mk[i] == 0) || (mk[i] == lat[i] + 1)) && !fl;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NI; i++) begin
            mk[i] = 0; mdest[i] = 0; e_waddr[i] = 0; e_cnt[i] = 0;
            e_rd[i] = 0; e_sel[i] = 0; e_we[i] = 0;
        end
    endtask

    // A load accepted at edge E occupies cycles E+1 .. E+1+L.
    // The model's k is the index of the current cycle within that span.
    task automatic modelAdvance(input bit v, input bit ld, input int d, input bit fl);
        for (int i = 0; i < NI; i++) begin
            bit acc;
            int nk;
            acc = v && modelReady(i, fl);
            nk = 0;
            if ((mk[i] >= 1) && (mk[i] <= lat[i]) && !fl) nk = mk[i] + 1;
            e_rd[i] = 0; e_sel[i] = 0; e_we[i] = 0;
            if (acc && ld) begin
                nk = 1;
                mdest[i] = d;
            end
            if (acc && !ld) begin
                e_we[i] = 1;
                e_waddr[i] = d;
            end
            if (nk >= 1) e_sel[i] = 1;
            if (nk == 1) e_rd[i] = 1;
            if (nk == lat[i] + 1) begin
                e_we[i] = 1;
                e_waddr[i] = mdest[i];
                if (e_cnt[i] < 255) e_cnt[i]++;
            end
            mk[i] = nk;
        end
    endtask

    task automatic checkReady(input bit fl);
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("ready%0d", i), int'(ready_a[i]), int'(modelReady(i, fl)));
            checkOutput($sformatf("stall%0d", i), int'(stall_a[i]), int'(!modelReady(i, fl)));
        end
    endtask

    task automatic checkRegistered();
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("mem_rd_en%0d", i), int'(rd_a[i]), int'(e_rd[i]));
            checkOutput($sformatf("mem_sel%0d", i), int'(sel_a[i]), int'(e_sel[i]));
            checkOutput($sformatf("reg_we%0d", i), int'(we_a[i]), int'(e_we[i]));
            checkOutput($sformatf("reg_waddr%0d", i), int'(waddr_a[i]), e_waddr[i]);
            checkOutput($sformatf("load_cnt%0d", i), int'(cnt_a[i]), e_cnt[i]);
        end
    endtask

    // One clock of stimulus: drive at negedge, check ready, then check registered outputs after the edge
    task automatic applyStimulus(input bit v, input bit ld, input logic [2:0] d, input bit fl);
        @(negedge clk);
        wb_valid = v; wb_is_load = ld; wb_dest = d; flush = fl;
        #1;
        checkReady(fl);
        @(posedge clk);
        modelAdvance(v, ld, int'(d), fl);
        #1;
        checkRegistered();
    endtask

    // Asynchronous reset between clock edges; outputs must clear without a clock
    task automatic asyncReset();
        wb_valid = 0; wb_is_load = 0; wb_dest = 0; flush = 0;
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkRegistered();
        checkReady(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        modelReset();
        #12;
        checkRegistered();
        checkReady(1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back ALU writes to 1, 2, 3
        applyStimulus(1, 0, 3'd1, 0);
        applyStimulus(1, 0, 3'd2, 0);
        applyStimulus(1, 0, 3'd3, 0);
        repeat (4) applyStimulus(0, 0, 3'd0, 0);

        // Single load to 5
        applyStimulus(1, 1, 3'd5, 0);
        repeat (6) applyStimulus(0, 0, 3'd0, 0);

        // Load to 4 followed by an ALU request to 6 held valid
        applyStimulus(1, 1, 3'd4, 0);
        repeat (5) applyStimulus(1, 0, 3'd6, 0);
        repeat (6) applyStimulus(0, 0, 3'd0, 0);

        // Load with flush two cycles after acceptance, then an ALU request
        applyStimulus(1, 1, 3'd2, 0);
        applyStimulus(0, 0, 3'd0, 0);
        applyStimulus(0, 0, 3'd0, 1);
        applyStimulus(1, 0, 3'd7, 0);
        repeat (6) applyStimulus(0, 0, 3'd0, 0);

        // Asynchronous reset in the middle of a load, then a normal load
        applyStimulus(1, 1, 3'd3, 0);
        applyStimulus(0, 0, 3'd0, 0);
        asyncReset();
        applyStimulus(1, 1, 3'd1, 0);
        repeat (6) applyStimulus(0, 0, 3'd0, 0);

        // Random traffic
        repeat (1500) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
        end

        // Continuous loads until every instance saturates its counter
        repeat (1100) applyStimulus(1, 1, 3'($urandom_range(0, 7)), 0);
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("saturated%0d", i), int'(cnt_a[i]), 255);
        end
        repeat (8) applyStimulus(1, 1, 3'($urandom_range(0, 7)), 0);
        repeat (6) applyStimulus(0, 0, 3'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
